uart_tx_param: RTL
==================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit, legal >= 2.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal 1 or 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tx_valid  input  1  frame request, qualified by tx_ready.
REQ-007 SHALL have port tx_ready  output  1  block can accept a frame this cycle.
REQ-008 SHALL have port tx_data  input  DATA_WIDTH  payload, sampled on acceptance.
REQ-009 SHALL have port parity_mode  input  2  00 none, 01 even, 10 odd, 11 none; sampled on acceptance.
REQ-010 SHALL have port tx_out  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-013 SHALL accept a frame in any cycle where tx_valid=1 and tx_ready=1; tx_ready SHALL be 1 only in IDLE.
REQ-014 SHALL capture tx_data and parity_mode at acceptance; later changes SHALL NOT affect the frame.
REQ-015 SHALL use states IDLE, START, DATA, PARITY, STOP: IDLE->START on acceptance; START->DATA; DATA->PARITY after DATA_WIDTH bits if parity active, else DATA->STOP; PARITY->STOP; STOP->IDLE after STOP_BITS bits.
REQ-016 SHALL drive tx_out low (start bit) from the cycle after acceptance.
REQ-017 SHALL hold each bit on tx_out for exactly CLKS_PER_BIT cycles via a bit-period counter reset at each bit boundary.
REQ-018 SHALL send data bits LSB first.
REQ-019 SHALL compute even parity as XOR of captured data, odd parity as its inverse; modes 00/11 SHALL omit the parity bit.
REQ-020 SHALL drive tx_out high during STOP and IDLE.
REQ-021 SHALL assert done for exactly one cycle, the last cycle of the last stop bit; next cycle SHALL be IDLE with tx_ready=1.
REQ-022 SHALL assert busy in all non-IDLE states; busy and tx_ready SHALL be mutually exclusive.
REQ-023 SHALL support back-to-back frames: a request held high SHALL be accepted in the first IDLE cycle, leaving exactly one idle-high cycle between frames.
REQ-024 Frame length SHALL be (1+DATA_WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles, P in {0,1}.

Reset
REQ-025 On reset SHALL enter IDLE, clear counters and shift register; next cycle tx_out=1, tx_ready=1, busy=0, done=0.
REQ-026 Reset mid-frame SHALL abort the frame without a done pulse; reset SHALL dominate a simultaneous tx_valid.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: PARITY state and parity_mode decoding SHALL be built as above.
REQ-028 Macro UART_TX_PARITY_EN undefined: PARITY state and parity logic SHALL be absent, parity_mode SHALL be ignored (port kept), P=0 always.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum type and the parity_mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-030 Sub-module uart_baud_cnt SHALL implement the CLKS_PER_BIT counter with a bit_end pulse; shift, parity and FSM stay in uart_tx_param.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-031 0xA5, even -> tx_out bit sequence 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles; done at cycle 44 after acceptance.
REQ-032 0x01, odd -> parity bit 0; 0x01, even -> parity bit 1; 0x01, mode 00 -> 10-bit frame, done at cycle 40.
REQ-033 tx_valid held high, 0x3C then 0xC3 -> second acceptance one cycle after done; exactly one idle-high cycle between frames.
REQ-034 Reset asserted in cycle 20 of a frame -> next cycle tx_out=1, tx_ready=1, busy=0; no done pulse.
REQ-035 tx_data/parity_mode changed during frame -> transmitted bits unchanged; tx_valid ignored while busy=1.
REQ-036 DATA_WIDTH=7, STOP_BITS=2, UART_TX_PARITY_EN undefined, 0x55 -> 10-bit frame 0,1,0,1,0,1,0,1,1,1; done at cycle 40.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and encodings for the UART transmitter.
// Holds the FSM state enum and the parity_mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // 2'b11 is treated like PAR_NONE.
  function automatic logic par_active(
    input logic [1:0] mode
  );
    return (mode == PAR_EVEN) ||
           (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, pulses bit_end_o on the last
// clk of each serial bit.
// Ports: clk, reset (sync, high), en_i (count while high),
//        bit_end_o (last cycle of the current bit period).
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic bit_end_o
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ?
    $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end_o = en_i &&
    (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Held at zero while idle so the first bit
  // after acceptance gets a full period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || bit_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter (start, LSB-first
// data, optional parity, 1-2 stop bits) with valid/ready request.
// Ports: clk, reset (sync, high), tx_valid/tx_ready handshake,
//   tx_data, parity_mode (00 none, 01 even, 10 odd, 11 none),
//   tx_out (idle high), busy, done (1-cycle pulse at frame end).
// Build option: define UART_TX_PARITY_EN to build the parity bit;
//   otherwise parity_mode is ignored and frames carry no parity.
module uart_tx_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [1:0]            parity_mode,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  done
);

  import uart_pkg::*;

  localparam int IW = $clog2(DATA_WIDTH);

  state_e                state_q;
  state_e                state_d;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] shreg_d;
  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         idx_d;
  logic                  stop_q;
  logic                  stop_d;

  logic bit_end;
  logic accept;
  logic last_stop;
  logic last_data;

`ifdef UART_TX_PARITY_EN
  logic par_bit_q;
  logic par_bit_d;
  logic par_en_q;
  logic par_en_d;
`else
  logic unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .reset     (reset),
    .en_i      (state_q != S_IDLE),
    .bit_end_o (bit_end)
  );

  assign accept    = tx_valid && tx_ready;
  assign last_data =
    (idx_q == IW'(DATA_WIDTH - 1));
  // stop_q marks that the first of two
  // stop bits has already gone out.
  assign last_stop =
    (STOP_BITS == 1) || stop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
`ifdef UART_TX_PARITY_EN
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    stop_d    = stop_q;
`ifdef UART_TX_PARITY_EN
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_START;
          shreg_d   = tx_data;
          idx_d     = '0;
          stop_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          // Parity is fixed at acceptance so
          // later input changes cannot leak in.
          par_en_d  = par_active(parity_mode);
          par_bit_d = (^tx_data) ^
            (parity_mode == PAR_ODD);
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (last_data) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ?
              S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_out   = 1'b1;
    tx_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_STOP) &&
               bit_end && last_stop;
    unique case (state_q)
      S_START: tx_out = 1'b0;
      S_DATA:  tx_out = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_out = par_bit_q;
`endif
      default: tx_out = 1'b1;
    endcase
  end

endmodule
